uart_rx_sampler: RTL and testbench

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

---
 rtl/uart_rx_sampler_if.sv | 22 ++
 rtl/uart_rx_sampler.sv | 99 +++++++++
 tb/tb_uart_rx_sampler.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sampler_if.sv
// Connects the RX FSM (master) to the oversampling bit sampler (slave).
// The master drives the serial line and the count enable; the sampler returns its counters and pulses.
interface uart_rx_sampler_if;
  logic       rx_in;
  logic       cnt_en;
  logic [4:0] edge_num;
  logic [3:0] bit_num;
  logic       sampled_bit;
  logic       sample_valid;
  logic       strt_glitch;
  logic       frame_done;

  modport master (
    output rx_in, cnt_en,
    input  edge_num, bit_num, sampled_bit, sample_valid, strt_glitch, frame_done
  );

  modport slave (
    input  rx_in, cnt_en,
    output edge_num, bit_num, sampled_bit, sample_valid, strt_glitch, frame_done
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling UART bit sampler: edge/bit counters, mid-bit capture and per-bit decision.
// Optional macro UART_RX_MAJORITY_VOTE_EN selects a 3-sample majority instead of the single mid sample.
module uart_rx_sampler #(
  parameter int PRESCALE   = 8,
  parameter int FRAME_BITS = 11
) (
  input  logic                clk,
  input  logic                rst,
  uart_rx_sampler_if.slave    bus
);

  localparam int         M         = PRESCALE / 2;
  localparam logic [4:0] EDGE_LAST = 5'(PRESCALE - 1);
  localparam logic [4:0] EDGE_S0   = 5'(M - 1);
  localparam logic [4:0] EDGE_S1   = 5'(M);
  localparam logic [4:0] EDGE_DEC  = 5'(M + 1);
  localparam logic [3:0] BIT_LAST  = 4'(FRAME_BITS - 1);

  logic [4:0] r_edge;
  logic [3:0] r_bit;
  logic       r_s1;
  logic       r_sampled;
  logic       r_valid;
  logic       r_glitch;
  logic       r_done;
  logic       w_decision;
  logic       w_edge_last;
  logic       w_at_dec;

  assign w_edge_last = (r_edge == EDGE_LAST);
  assign w_at_dec    = (r_edge == EDGE_DEC);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic r_s0;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0 <= 1'b1;
    end else if (!bus.cnt_en) begin
      r_s0 <= 1'b1;
    end else if (r_edge == EDGE_S0) begin
      r_s0 <= bus.rx_in;
    end
  end

  // The third vote is the live line at M+1, so the decision lands one clock after it.
  assign w_decision = majority3(r_s0, r_s1, bus.rx_in);
`else
  assign w_decision = r_s1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge    <= 5'd0;
      r_bit     <= 4'd0;
      r_s1      <= 1'b1;
      r_sampled <= 1'b1;
      r_valid   <= 1'b0;
      r_glitch  <= 1'b0;
      r_done    <= 1'b0;
    end else if (!bus.cnt_en) begin
      // Dropping the enable throws away any half-captured bit; sampled_bit keeps its last decision.
      r_edge   <= 5'd0;
      r_bit    <= 4'd0;
      r_s1     <= 1'b1;
      r_valid  <= 1'b0;
      r_glitch <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_valid  <= w_at_dec;
      r_glitch <= w_at_dec && (r_bit == 4'd0) && w_decision;
      r_done   <= w_edge_last && (r_bit == BIT_LAST);
      if (r_edge == EDGE_S1) begin
        r_s1 <= bus.rx_in;
      end
      if (w_at_dec) begin
        r_sampled <= w_decision;
      end
      if (w_edge_last) begin
        r_edge <= 5'd0;
        r_bit  <= (r_bit == BIT_LAST) ? 4'd0 : r_bit + 4'd1;
      end else begin
        r_edge <= r_edge + 5'd1;
      end
    end
  end

  assign bus.edge_num     = r_edge;
  assign bus.bit_num      = r_bit;
  assign bus.sampled_bit  = r_sampled;
  assign bus.sample_valid = r_valid;
  assign bus.strt_glitch  = r_glitch;
  assign bus.frame_done   = r_done;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: three instances (PRESCALE 8/16/32) share one stimulus stream
// and are compared each cycle against a cycle-count reference model, plus directed frame checks.
module tb_uart_rx_sampler;
  localparam int F = 11;

  logic clk = 1'b0;
  logic rst, rx, en;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  uart_rx_sampler_if if8 ();
  uart_rx_sampler_if if16 ();
  uart_rx_sampler_if if32 ();

  assign if8.rx_in   = rx;
  assign if8.cnt_en  = en;
  assign if16.rx_in  = rx;
  assign if16.cnt_en = en;
  assign if32.rx_in  = rx;
  assign if32.cnt_en = en;

  uart_rx_sampler #(.PRESCALE(8),  .FRAME_BITS(F)) dut8  (.clk(clk), .rst(rst), .bus(if8));
  uart_rx_sampler #(.PRESCALE(16), .FRAME_BITS(F)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  uart_rx_sampler #(.PRESCALE(32), .FRAME_BITS(F)) dut32 (.clk(clk), .rst(rst), .bus(if32));

  logic [4:0] o_edge [3];
  logic [3:0] o_bit  [3];
  logic       o_sb [3], o_sv [3], o_sg [3], o_fd [3];

  assign o_edge[0] = if8.edge_num;   assign o_edge[1] = if16.edge_num;   assign o_edge[2] = if32.edge_num;
  assign o_bit[0]  = if8.bit_num;    assign o_bit[1]  = if16.bit_num;    assign o_bit[2]  = if32.bit_num;
  assign o_sb[0]   = if8.sampled_bit;  assign o_sb[1] = if16.sampled_bit;  assign o_sb[2] = if32.sampled_bit;
  assign o_sv[0]   = if8.sample_valid; assign o_sv[1] = if16.sample_valid; assign o_sv[2] = if32.sample_valid;
  assign o_sg[0]   = if8.strt_glitch;  assign o_sg[1] = if16.strt_glitch;  assign o_sg[2] = if32.strt_glitch;
  assign o_fd[0]   = if8.frame_done;   assign o_fd[1] = if16.frame_done;   assign o_fd[2] = if32.frame_done;

  // Reference model: position in the frame is just the count of enabled clocks since restart.
  int   PS [3] = '{8, 16, 32};
  int   m_t [3];
  logic m_line [3][32];
  logic [4:0] x_edge [3];
  logic [3:0] x_bit  [3];
  logic x_sb [3], x_sv [3], x_sg [3], x_fd [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_t[k] = 0; x_edge[k] = 5'd0; x_bit[k] = 4'd0;
      x_sb[k] = 1'b1; x_sv[k] = 1'b0; x_sg[k] = 1'b0; x_fd[k] = 1'b0;
      for (int i = 0; i < 32; i++) m_line[k][i] = 1'b1;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 3; k++) begin
      int p, m, e, b;
      logic dec;
      p = PS[k]; m = p / 2;
      x_sv[k] = 1'b0; x_sg[k] = 1'b0; x_fd[k] = 1'b0;
      if (en) begin
        e = m_t[k] % p;
        b = m_t[k] / p;
        m_line[k][e] = rx;
        if (e == m + 1) begin
`ifdef UART_RX_MAJORITY_VOTE_EN
          dec = ((int'(m_line[k][m-1]) + int'(m_line[k][m]) + int'(rx)) >= 2);
`else
          dec = m_line[k][m];
`endif
          x_sb[k] = dec;
          x_sv[k] = 1'b1;
          x_sg[k] = (b == 0) && dec;
        end
        x_fd[k] = (e == p - 1) && (b == F - 1);
        m_t[k] = (m_t[k] + 1) % (p * F);
      end else begin
        m_t[k] = 0;
      end
      x_edge[k] = 5'(m_t[k] % p);
      x_bit[k]  = 4'(m_t[k] / p);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("edge_num_p%0d", PS[k]),     32'(o_edge[k]), 32'(x_edge[k]));
      check($sformatf("bit_num_p%0d", PS[k]),      32'(o_bit[k]),  32'(x_bit[k]));
      check($sformatf("sampled_bit_p%0d", PS[k]),  32'(o_sb[k]),   32'(x_sb[k]));
      check($sformatf("sample_valid_p%0d", PS[k]), 32'(o_sv[k]),   32'(x_sv[k]));
      check($sformatf("strt_glitch_p%0d", PS[k]),  32'(o_sg[k]),   32'(x_sg[k]));
      check($sformatf("frame_done_p%0d", PS[k]),   32'(o_fd[k]),   32'(x_fd[k]));
      if (o_sv[k]) check($sformatf("valid_edge_p%0d", PS[k]), 32'(o_edge[k]), 32'(PS[k] / 2 + 2));
    end
  endtask

  task automatic step(input logic r, input logic e);
    rx = r;
    en = e;
    model_clock();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  logic frame_a5 [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int   idx, cnt;
  logic lone_one;

  initial begin
    rst = 1'b1; rx = 1'b1; en = 1'b0;
    do_reset();

    // All-zero line: full frame of 88 clocks plus wrap, start bit never flagged.
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1);

    // 0xA5 with even parity, sampled bit sequence read at each sample_valid.
    step(1'b1, 1'b0);
    idx = 0;
    for (int b = 0; b < 11; b++) begin
      for (int e = 0; e < 8; e++) begin
        step(frame_a5[b], 1'b1);
        if (o_sv[0]) begin
          check($sformatf("a5_bit%0d", idx), 32'(o_sb[0]), 32'(frame_a5[idx < 11 ? idx : 10]));
          idx++;
        end
      end
    end
    check("a5_count", 32'(idx), 32'd11);

    // Single high sample at edge 4 of a zero bit.
    step(1'b1, 1'b0);
    lone_one = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step(e == 4, 1'b1);
      if (o_sv[0]) lone_one = o_sb[0];
    end
`ifdef UART_RX_MAJORITY_VOTE_EN
    check("lone_one_vote", 32'(lone_one), 32'd0);
`else
    check("lone_one_single", 32'(lone_one), 32'd1);
`endif

    // Start bit high at edges 3..5 flags exactly one glitch at edge 6 of bit 0.
    step(1'b1, 1'b0);
    cnt = 0;
    for (int t = 0; t < 88; t++) begin
      step((t >= 3) && (t <= 5), 1'b1);
      if (o_sg[0]) begin
        cnt++;
        check("glitch_edge", 32'(o_edge[0]), 32'd6);
        check("glitch_bit",  32'(o_bit[0]),  32'd0);
      end
    end
    check("glitch_count", 32'(cnt), 32'd1);

    // Enable drop at bit 4 edge 2, then reset mid-frame at bit 7.
    step(1'b1, 1'b0);
    for (int t = 0; t < 34; t++) step(1'($urandom_range(0, 1)), 1'b1);
    check("pre_drop_bit", 32'(o_bit[0]), 32'd4);
    step(1'b0, 1'b0);
    check("drop_edge", 32'(o_edge[0]), 32'd0);
    check("drop_bit",  32'(o_bit[0]),  32'd0);
    for (int t = 0; t < 59; t++) step(1'b0, 1'b1);
    do_reset();
    check("rst_sampled", 32'(o_sb[0]), 32'd1);
    cnt = 0;
    for (int t = 0; t < 40; t++) begin
      step(1'b0, 1'b1);
      if (o_fd[0]) cnt++;
    end
    check("no_frame_done", 32'(cnt), 32'd0);

    // Randomized line and enable with rare resets.
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), $urandom_range(0, 99) < 97);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
